rhd_cmd_engine: RTL and testbench

// - Subordinate command engine for one RHD headstage SPI port; the responder side of the

---
 rtl/rhd_cmd_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_rhd_cmd_engine.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhd_cmd_engine.sv
// RHD headstage command engine: responder side of the start -> busy/done handshake.
// Each accepted command streams a fixed list of 16-bit SPI words (CS/SCLK/MOSI),
// captures MISO per word, emits convert results as samples, then pulses done.
module rhd_cmd_engine #(
    parameter int unsigned NUM_CH      = 32,
    parameter int unsigned HALF_PERIOD = 2,
    parameter int unsigned CS_GAP      = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        config_start,
    input  logic        record_start,
    input  logic        zcheck_start,
    input  logic [5:0]  zcheck_channel,
    output logic        busy,
    output logic        done,
    output logic        CS,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [15:0] sample_data,
    output logic [5:0]  sample_channel,
    output logic        sample_valid
);

    // One phase counter serves both the SCLK half-period and the CS gap.
    localparam int unsigned PH_MAX = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] HP_LAST  = PH_W'(HALF_PERIOD - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(CS_GAP - 1);

    localparam logic [15:0] READ_40   = {2'b11, 6'd40, 8'h00};
    localparam logic [15:0] CALIBRATE = 16'h5500;

    typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;
    typedef enum logic [1:0] {CmdConfig, CmdZcheck, CmdRecord} cmd_e;

    state_e          state_q, state_d;
    cmd_e            cmd_q, cmd_d;
    cmd_e            new_cmd;
    logic [5:0]      zch_q, zch_d;
    logic [6:0]      word_q, word_d;
    logic [3:0]      bit_q, bit_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [15:0]     tx_q, tx_d;
    logic [15:0]     rx_q, rx_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sv_q, sv_d;
    logic [15:0]     sdata_q, sdata_d;
    logic [5:0]      sch_q, sch_d;
    logic            start_any;
    logic [15:0]     first_word;
    logic [15:0]     next_word;

    // Config register init values for registers 0..7.
    function automatic logic [7:0] cfg_val(input logic [2:0] r);
        logic [7:0] v;
        case (r)
            3'd0:    v = 8'hDE;
            3'd1:    v = 8'h20;
            3'd2:    v = 8'h28;
            3'd4:    v = 8'h80;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Index of the final word of each command sequence.
    function automatic logic [6:0] last_word(input cmd_e cmd);
        logic [6:0] n;
        case (cmd)
            CmdConfig: n = 7'd17;
            CmdZcheck: n = 7'd2;
            default:   n = 7'(NUM_CH + 1);
        endcase
        return n;
    endfunction

    // SPI word number idx of the given command's sequence.
    function automatic logic [15:0] word_of(input cmd_e cmd, input logic [6:0] idx,
                                            input logic [5:0] ch);
        logic [15:0] w;
        w = 16'h0000;
        case (cmd)
            CmdConfig: begin
                if (idx < 7'd8) begin
                    w = {2'b10, 3'b000, idx[2:0], cfg_val(idx[2:0])};
                end else if (idx == 7'd8) begin
                    w = CALIBRATE;
                end else begin
                    w = READ_40;
                end
            end
            CmdZcheck: w = (idx == 7'd0) ? {2'b10, 6'd7, 2'b00, ch} : READ_40;
            // Words past the channel list are CONVERT(0) flush words.
            default:   w = (32'(idx) < NUM_CH) ? {2'b00, idx[5:0], 8'h00} : 16'h0000;
        endcase
        return w;
    endfunction

    assign start_any  = config_start | zcheck_start | record_start;
    assign new_cmd    = config_start ? CmdConfig : (zcheck_start ? CmdZcheck : CmdRecord);
    assign first_word = word_of(new_cmd, 7'd0, zcheck_channel);
    assign next_word  = word_of(cmd_q, word_q + 7'd1, zch_q);

    // Sequencer next-state: command accept, bit shifting, inter-word gap, done pulse.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        zch_d   = zch_q;
        word_d  = word_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sv_d    = 1'b0;
        sdata_d = sdata_q;
        sch_d   = sch_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                // Leaving DONE is the IDLE re-entry point: a start still held here is
                // accepted at once, so busy is low only for the done cycle.
                if (start_any) begin
                    state_d = StShift;
                    cmd_d   = new_cmd;
                    zch_d   = zcheck_channel;
                    word_d  = 7'd0;
                    bit_d   = 4'd15;
                    phase_d = '0;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    tx_d    = first_word;
                    mosi_d  = first_word[15];
                end
            end
            StShift: begin
                if (phase_q != HP_LAST) begin
                    phase_d = phase_q + 1'b1;
                end else begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        // Rising SCLK edge: capture MISO MSB first.
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[14:0], MISO};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            cs_d    = 1'b1;
                            state_d = StGap;
                            // Record word k carries the result of CONVERT issued in word k-2.
                            if (cmd_q == CmdRecord && word_q >= 7'd2) begin
                                sv_d    = 1'b1;
                                sdata_d = rx_q;
                                sch_d   = 6'(word_q - 7'd2);
                            end
                        end else begin
                            bit_d  = bit_q - 4'd1;
                            tx_d   = {tx_q[14:0], tx_q[15]};
                            mosi_d = tx_q[14];
                        end
                    end
                end
            end
            StGap: begin
                if (phase_q != GAP_LAST) begin
                    phase_d = phase_q + 1'b1;
                end else begin
                    phase_d = '0;
                    if (word_q == last_word(cmd_q)) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StShift;
                        word_d  = word_q + 7'd1;
                        bit_d   = 4'd15;
                        cs_d    = 1'b0;
                        tx_d    = next_word;
                        mosi_d  = next_word[15];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cmd_q   <= CmdConfig;
            zch_q   <= 6'd0;
            word_q  <= 7'd0;
            bit_q   <= 4'd0;
            phase_q <= '0;
            tx_q    <= 16'h0000;
            rx_q    <= 16'h0000;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sv_q    <= 1'b0;
            sdata_q <= 16'h0000;
            sch_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            zch_q   <= zch_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sv_q    <= sv_d;
            sdata_q <= sdata_d;
            sch_q   <= sch_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign CS             = cs_q;
    assign SCLK           = sclk_q;
    assign MOSI           = mosi_q;
    assign sample_valid   = sv_q;
    assign sample_data    = sdata_q;
    assign sample_channel = sch_q;

endmodule

// File: tb/tb_rhd_cmd_engine.sv
// Bench for rhd_cmd_engine: two instances (default timing and the fastest timing),
// a behavioural RHD chip with a two-word result pipeline, and a word/sample scoreboard.
module tb_rhd_cmd_engine;

    localparam int NCH0 = 32, HP0 = 2, GAP0 = 4;
    localparam int NCH1 = 5,  HP1 = 1, GAP1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        cfg_s [2];
    logic        rec_s [2];
    logic        zck_s [2];
    logic [5:0]  zch   [2];
    logic        miso  [2];
    logic        busy  [2];
    logic        done  [2];
    logic        cs    [2];
    logic        sclk  [2];
    logic        mosi  [2];
    logic        sv    [2];
    logic [15:0] sdata [2];
    logic [5:0]  sch   [2];

    rhd_cmd_engine #(.NUM_CH(NCH0), .HALF_PERIOD(HP0), .CS_GAP(GAP0)) u_dut0 (
        .clk(clk), .rstn(rstn), .config_start(cfg_s[0]), .record_start(rec_s[0]),
        .zcheck_start(zck_s[0]), .zcheck_channel(zch[0]), .busy(busy[0]), .done(done[0]),
        .CS(cs[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .MISO(miso[0]), .sample_data(sdata[0]),
        .sample_channel(sch[0]), .sample_valid(sv[0])
    );

    rhd_cmd_engine #(.NUM_CH(NCH1), .HALF_PERIOD(HP1), .CS_GAP(GAP1)) u_dut1 (
        .clk(clk), .rstn(rstn), .config_start(cfg_s[1]), .record_start(rec_s[1]),
        .zcheck_start(zck_s[1]), .zcheck_channel(zch[1]), .busy(busy[1]), .done(done[1]),
        .CS(cs[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .MISO(miso[1]), .sample_data(sdata[1]),
        .sample_channel(sch[1]), .sample_valid(sv[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    int cur = 0, cur_hp = HP0, cur_gap = GAP0, cur_nch = NCH0;
    logic [15:0] chan_val [64];

    // Written only by the monitor process.
    logic [15:0] cap_words [$];
    logic [15:0] samp_d [$];
    logic [5:0]  samp_c [$];
    int done_cnt = 0, bad_cs = 0, bad_gap = 0, bad_sclk = 0, bad_hs = 0, bad_sv = 0;

    logic [15:0] exp_w [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Chip reply to a received word: convert results come from the channel table.
    function automatic logic [15:0] chip_resp(input logic [15:0] w);
        if (w[15:14] == 2'b00) return chan_val[w[13:8]];
        return 16'($urandom);
    endfunction

    // Chip model and protocol monitor, sampled on the falling clock edge.
    initial begin
        logic c, s, m, b, d;
        logic prev_cs, prev_sclk, prev_busy, prev_done;
        logic [15:0] rx_word, tx, pipe1, pipe2;
        int rx_bits, tx_pos, cs_len, gap_len, hi_len;
        miso[0] = 1'b0; miso[1] = 1'b0;
        prev_cs = 1'b1; prev_sclk = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
        rx_word = '0; tx = '0; pipe1 = '0; pipe2 = '0;
        rx_bits = 0; tx_pos = 0; cs_len = 0; gap_len = 0; hi_len = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_cs = 1'b1; prev_sclk = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
                pipe1 = '0; pipe2 = '0; rx_bits = 0; cs_len = 0; gap_len = 0; hi_len = 0;
            end else begin
                c = cs[cur]; s = sclk[cur]; m = mosi[cur]; b = busy[cur]; d = done[cur];
                if ((prev_busy && !b && !d) || (b && d) || (d && prev_done)) bad_hs++;
                if (d) done_cnt++;
                if (sv[cur]) begin
                    samp_d.push_back(sdata[cur]);
                    samp_c.push_back(sch[cur]);
                    if (!(c && !prev_cs)) bad_sv++;
                end
                if (!c && prev_cs) begin
                    if (prev_busy && gap_len != cur_gap) bad_gap++;
                    tx = pipe2; tx_pos = 15; miso[cur] = tx[15];
                    rx_bits = 0; cs_len = 0; hi_len = 0;
                end
                if (c && !prev_cs) begin
                    if (cs_len != 32 * cur_hp) bad_cs++;
                    if (rx_bits == 16) begin
                        cap_words.push_back(rx_word);
                        pipe2 = pipe1;
                        pipe1 = chip_resp(rx_word);
                    end
                    gap_len = 0;
                end
                if (!c) cs_len++; else gap_len++;
                if (!c && s && !prev_sclk) begin
                    rx_word = {rx_word[14:0], m};
                    rx_bits++;
                end
                if (s) hi_len++;
                if (!s && prev_sclk) begin
                    if (hi_len != cur_hp) bad_sclk++;
                    hi_len = 0;
                    if (!c) begin
                        tx_pos--;
                        if (tx_pos >= 0) miso[cur] = tx[tx_pos];
                    end
                end
                prev_cs = c; prev_sclk = s; prev_busy = b; prev_done = d;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
        $fatal(1);
    end

    task automatic select_inst(input int i);
        cur     = i;
        cur_hp  = (i == 0) ? HP0 : HP1;
        cur_gap = (i == 0) ? GAP0 : GAP1;
        cur_nch = (i == 0) ? NCH0 : NCH1;
    endtask

    task automatic set_start(input int kind, input logic v);
        case (kind)
            0:       cfg_s[cur] = v;
            1:       zck_s[cur] = v;
            default: rec_s[cur] = v;
        endcase
    endtask

    task automatic randomize_chans();
        for (int i = 0; i < 64; i++) chan_val[i] = 16'($urandom);
    endtask

    // Reference word list for one command (kind 0 config, 1 zcheck, 2 record), appended.
    task automatic build_exp(input int kind, input logic [5:0] ch, input int nch);
        logic [7:0] vals [8];
        vals = '{8'hDE, 8'h20, 8'h28, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
        if (kind == 0) begin
            for (int r = 0; r < 8; r++) exp_w.push_back(16'h8000 | (16'(r) << 8) | 16'(vals[r]));
            exp_w.push_back(16'h5500);
            for (int k = 0; k < 9; k++) exp_w.push_back(16'hC000 | (16'd40 << 8));
        end else if (kind == 1) begin
            exp_w.push_back(16'h8000 | (16'd7 << 8) | 16'(ch));
            for (int k = 0; k < 2; k++) exp_w.push_back(16'hC000 | (16'd40 << 8));
        end else begin
            for (int k = 0; k < nch; k++) exp_w.push_back(16'(k) << 8);
            exp_w.push_back(16'h0000);
            exp_w.push_back(16'h0000);
        end
    endtask

    task automatic compare_words(input int wbase);
        check_eq("word_count", 32'(cap_words.size() - wbase), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++)
            if (wbase + i < cap_words.size())
                check_eq($sformatf("mosi_word%0d", i), 32'(cap_words[wbase + i]), 32'(exp_w[i]));
    endtask

    task automatic compare_samples(input int sbase, input int nsamp);
        check_eq("sample_count", 32'(samp_d.size() - sbase), 32'(nsamp));
        for (int n = 0; n < nsamp; n++)
            if (sbase + n < samp_d.size()) begin
                check_eq($sformatf("sample_ch%0d", n), 32'(samp_c[sbase + n]), 32'(n));
                check_eq($sformatf("sample_data%0d", n), 32'(samp_d[sbase + n]),
                         32'(chan_val[n]));
            end
    endtask

    task automatic wait_busy_low(output int blen);
        int t;
        blen = 0; t = 0;
        @(negedge clk);
        while (busy[cur] && t < 6000) begin blen++; t++; @(negedge clk); end
    endtask

    // Issue one command with the level-start handshake and score everything it did.
    task automatic run_cmd(input int kind, input logic [5:0] ch);
        int wbase, sbase, dbase, spi0, hs0, blen, nw;
        wbase = cap_words.size(); sbase = samp_d.size(); dbase = done_cnt;
        spi0 = bad_cs + bad_gap + bad_sclk; hs0 = bad_hs + bad_sv;
        nw = (kind == 0) ? 18 : (kind == 1) ? 3 : cur_nch + 2;
        @(posedge clk); #1;
        zch[cur] = ch;
        set_start(kind, 1'b1);
        @(posedge clk); #1;
        check_eq("accept_busy", 32'(busy[cur]), 1);
        set_start(kind, 1'b0);
        zch[cur] = ch ^ 6'($urandom_range(1, 63));
        wait_busy_low(blen);
        check_eq("busy_len", 32'(blen), 32'(nw * (32 * cur_hp + cur_gap)));
        check_eq("done_pulse", 32'(done[cur]), 1);
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done[cur]), 0);
        check_eq("done_count", 32'(done_cnt - dbase), 1);
        exp_w.delete();
        build_exp(kind, ch, cur_nch);
        compare_words(wbase);
        compare_samples(sbase, (kind == 2) ? cur_nch : 0);
        check_eq("spi_timing_errs", 32'(bad_cs + bad_gap + bad_sclk - spi0), 0);
        check_eq("handshake_errs", 32'(bad_hs + bad_sv - hs0), 0);
        repeat ($urandom_range(0, 5)) @(negedge clk);
    endtask

    initial begin
        int wbase, sbase, dbase, blen, low, t;
        for (int i = 0; i < 2; i++) begin
            cfg_s[i] = 1'b0; rec_s[i] = 1'b0; zck_s[i] = 1'b0; zch[i] = 6'd0;
        end
        randomize_chans();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_busy", 32'(busy[i]), 0);
            check_eq("rst_done", 32'(done[i]), 0);
            check_eq("rst_cs", 32'(cs[i]), 1);
            check_eq("rst_sclk", 32'(sclk[i]), 0);
            check_eq("rst_mosi", 32'(mosi[i]), 0);
            check_eq("rst_sv", 32'(sv[i]), 0);
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Default-timing instance.
        select_inst(0);
        wbase = cap_words.size();
        run_cmd(0, 6'd0);
        if (cap_words.size() >= wbase + 9) begin
            check_eq("cfg_first_word", 32'(cap_words[wbase]), 32'h80DE);
            check_eq("cfg_ninth_word", 32'(cap_words[wbase + 8]), 32'h5500);
        end
        randomize_chans();
        run_cmd(2, 6'd0);
        wbase = cap_words.size();
        run_cmd(1, 6'd13);
        if (cap_words.size() >= wbase + 3) begin
            check_eq("zck_word0", 32'(cap_words[wbase]), 32'h870D);
            check_eq("zck_word1", 32'(cap_words[wbase + 1]), 32'hE800);
        end
        for (int k = 0; k < 3; k++) run_cmd(1, 6'($urandom_range(0, 63)));

        // Config and record requested together: config first, record back-to-back.
        randomize_chans();
        wbase = cap_words.size(); sbase = samp_d.size(); dbase = done_cnt;
        @(posedge clk); #1;
        cfg_s[0] = 1'b1; rec_s[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("combo_accept", 32'(busy[0]), 1);
        cfg_s[0] = 1'b0;
        wait_busy_low(blen);
        check_eq("combo_cfg_busy", 32'(blen), 1224);
        check_eq("combo_cfg_done", 32'(done[0]), 1);
        low = 0; t = 0;
        while (!busy[0] && t < 20) begin low++; t++; @(negedge clk); end
        check_eq("combo_busy_low", 32'(low), 1);
        rec_s[0] = 1'b0;
        blen = 0; t = 0;
        while (busy[0] && t < 6000) begin blen++; t++; @(negedge clk); end
        check_eq("combo_rec_busy", 32'(blen), 2312);
        check_eq("combo_rec_done", 32'(done[0]), 1);
        @(negedge clk);
        check_eq("combo_done_count", 32'(done_cnt - dbase), 2);
        exp_w.delete();
        build_exp(0, 6'd0, NCH0);
        build_exp(2, 6'd0, NCH0);
        compare_words(wbase);
        compare_samples(sbase, NCH0);

        // Reset in the middle of record word 5.
        wbase = cap_words.size();
        @(posedge clk); #1;
        rec_s[0] = 1'b1;
        @(posedge clk); #1;
        rec_s[0] = 1'b0;
        t = 0;
        while (cap_words.size() < wbase + 5 && t < 1000) begin t++; @(negedge clk); end
        repeat (20) @(negedge clk);
        check_eq("pre_reset_cs_low", 32'(cs[0]), 0);
        #2 rstn = 1'b0;
        #1;
        check_eq("mid_rst_cs", 32'(cs[0]), 1);
        check_eq("mid_rst_sclk", 32'(sclk[0]), 0);
        check_eq("mid_rst_busy", 32'(busy[0]), 0);
        check_eq("mid_rst_done", 32'(done[0]), 0);
        check_eq("mid_rst_mosi", 32'(mosi[0]), 0);
        check_eq("mid_rst_sv", 32'(sv[0]), 0);
        check_eq("mid_rst_sdata", 32'(sdata[0]), 0);
        check_eq("mid_rst_sch", 32'(sch[0]), 0);
        wbase = cap_words.size(); sbase = samp_d.size(); dbase = done_cnt;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("post_rst_busy", 32'(busy[0]), 0);
        check_eq("post_rst_cs", 32'(cs[0]), 1);
        check_eq("post_rst_sclk", 32'(sclk[0]), 0);
        check_eq("post_rst_sdata", 32'(sdata[0]), 0);
        check_eq("post_rst_no_done", 32'(done_cnt - dbase), 0);
        check_eq("post_rst_no_sample", 32'(samp_d.size() - sbase), 0);
        check_eq("post_rst_no_word", 32'(cap_words.size() - wbase), 0);

        // Fastest-timing instance: 2-cycle SCLK, 33-cycle word period.
        select_inst(1);
        randomize_chans();
        run_cmd(2, 6'd0);
        run_cmd(1, 6'($urandom_range(0, 63)));
        randomize_chans();
        run_cmd(2, 6'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
